// File: rtl/udma_qspi_cmd_seq_pkg.sv
// Shared definitions for the QSPI command sequencer: register map, CTRL field
// positions and the sequencer state encoding.
package qspi_pkg;

  localparam logic [4:0] ADDR_CTRL   = 5'h10;
  localparam logic [4:0] ADDR_GAP    = 5'h11;
  localparam logic [4:0] ADDR_STATUS = 5'h12;

  localparam int CTRL_LAST_LSB   = 0;
  localparam int CTRL_REPEAT_LSB = 8;
  localparam int CTRL_START_BIT  = 16;
  localparam int CTRL_ABORT_BIT  = 17;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_GAP
  } seq_state_e;

endpackage

// File: rtl/udma_qspi_cmd_seq_if.sv
// Configuration bus between the sequencer top and its register file.
interface udma_qspi_cmd_seq_if;

  logic [31:0] wdata;
  logic [4:0]  addr;
  logic        valid;
  logic        rwn;
  logic [31:0] rdata;

  modport master (output wdata, addr, valid, rwn, input rdata);
  modport slave  (input wdata, addr, valid, rwn, output rdata);

endinterface

// File: rtl/udma_qspi_cmd_seq_regs.sv
// Register file for the command sequencer: command buffer, CTRL/GAP fields,
// the start-pending flag and the combinational read mux.
module qspi_cmd_seq_regs
  import qspi_pkg::*;
#(
  parameter  int DEPTH = 8,
  parameter  int GAP_W = 16,
  localparam int IDXW  = $clog2(DEPTH)
) (
  input  logic                i_sysClk,
  input  logic                i_rstn,
  udma_qspi_cmd_seq_if.slave  cfg,
  input  logic                i_busy,
  input  logic                i_launch,
  input  logic [IDXW-1:0]     i_idx,
  input  logic [7:0]          i_passes,
  output logic [31:0]         o_bufWord,
  output logic [IDXW-1:0]     o_last,
  output logic [7:0]          o_repeat,
  output logic [GAP_W-1:0]    o_gap,
  output logic                o_startReq,
  output logic                o_abort
);

  logic [31:0]      r_buf [DEPTH];
  logic [IDXW-1:0]  r_last;
  logic [7:0]       r_repeat;
  logic [GAP_W-1:0] r_gap;
  logic             r_startPending;

  logic             w_wr;
  logic             w_cfgWrOk;
  logic             w_ctrlWr;
  logic             w_ctrlWrOk;
  logic             w_startWr;
  logic             w_bufSel;
  logic [3:0]       w_lastField;
  logic [IDXW-1:0]  w_lastClamped;

  // Configuration is frozen while a sequence is running or about to launch;
  // ABORT is decoded from the raw write so it always gets through.
  assign w_wr          = cfg.valid && !cfg.rwn;
  assign w_cfgWrOk     = w_wr && !i_busy && !r_startPending;
  assign w_ctrlWr      = w_wr && (cfg.addr == ADDR_CTRL);
  assign w_ctrlWrOk    = w_cfgWrOk && (cfg.addr == ADDR_CTRL);
  assign o_abort       = w_ctrlWr && cfg.wdata[CTRL_ABORT_BIT];
  assign w_startWr     = w_ctrlWr && cfg.wdata[CTRL_START_BIT] && !i_busy && !o_abort;
  assign o_startReq    = (r_startPending || w_startWr) && !o_abort;
  assign w_bufSel      = (cfg.addr < 5'(DEPTH));
  assign w_lastField   = cfg.wdata[CTRL_LAST_LSB +: 4];
  assign w_lastClamped = (w_lastField > 4'(DEPTH - 1)) ? IDXW'(DEPTH - 1) : w_lastField[IDXW-1:0];

  // A START written together with REPEAT launches in the same cycle, so the
  // freshly written count is forwarded instead of the stored one.
  assign o_repeat  = w_ctrlWrOk ? cfg.wdata[CTRL_REPEAT_LSB +: 8] : r_repeat;
  assign o_last    = r_last;
  assign o_gap     = r_gap;
  assign o_bufWord = r_buf[i_idx];

  // Command buffer storage
  always_ff @(posedge i_sysClk or negedge i_rstn) begin
    if (!i_rstn) begin
      for (int i = 0; i < DEPTH; i++) r_buf[i] <= '0;
    end else if (w_cfgWrOk && w_bufSel) begin
      r_buf[cfg.addr[IDXW-1:0]] <= cfg.wdata;
    end
  end

  // CTRL LAST/REPEAT fields and the inter-pass gap length
  always_ff @(posedge i_sysClk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_last   <= '0;
      r_repeat <= '0;
      r_gap    <= '0;
    end else begin
      if (w_ctrlWrOk) begin
        r_last   <= w_lastClamped;
        r_repeat <= cfg.wdata[CTRL_REPEAT_LSB +: 8];
      end
      if (w_cfgWrOk && (cfg.addr == ADDR_GAP)) begin
        r_gap <= cfg.wdata[GAP_W-1:0];
      end
    end
  end

  // START is remembered until the upstream stream lets the sequencer take over
  always_ff @(posedge i_sysClk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_startPending <= 1'b0;
    end else if (o_abort || i_launch) begin
      r_startPending <= 1'b0;
    end else if (w_startWr) begin
      r_startPending <= 1'b1;
    end
  end

  // Read data decode, purely from the address
  always_comb begin
    cfg.rdata = '0;
    if (w_bufSel) begin
      cfg.rdata = r_buf[cfg.addr[IDXW-1:0]];
    end else begin
      case (cfg.addr)
        ADDR_CTRL: begin
          cfg.rdata[CTRL_LAST_LSB +: 4]   = 4'(r_last);
          cfg.rdata[CTRL_REPEAT_LSB +: 8] = r_repeat;
        end
        ADDR_GAP:    cfg.rdata[GAP_W-1:0] = r_gap;
        ADDR_STATUS: begin
          cfg.rdata[0]    = i_busy;
          cfg.rdata[1]    = r_startPending;
          cfg.rdata[15:8] = i_passes;
        end
        default: cfg.rdata = '0;
      endcase
    end
  end

endmodule

// File: rtl/udma_qspi_cmd_seq.sv
// QSPI command sequencer: replays a programmable list of command words onto
// the QSPI command stream and otherwise passes uDMA commands straight through.
module udma_qspi_cmd_seq
  import qspi_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int GAP_W = 16
) (
  input  logic        sys_clk_i,
  input  logic        rstn_i,
  input  logic [31:0] cfg_data_i,
  input  logic [4:0]  cfg_addr_i,
  input  logic        cfg_valid_i,
  input  logic        cfg_rwn_i,
  output logic        cfg_ready_o,
  output logic [31:0] cfg_data_o,
  input  logic [31:0] udma_cmd_i,
  input  logic        udma_cmd_valid_i,
  output logic        udma_cmd_ready_o,
  output logic [31:0] cmd_o,
  output logic        cmd_valid_o,
  input  logic        cmd_ready_i,
  output logic        busy_o,
  output logic        done_evt_o
);

  localparam int IDXW = $clog2(DEPTH);

  udma_qspi_cmd_seq_if u_cfgBus ();

  seq_state_e       r_state,    w_stateNext;
  logic [IDXW-1:0]  r_idx,      w_idxNext;
  logic [7:0]       r_passes,   w_passesNext;
  logic [GAP_W-1:0] r_gapCnt,   w_gapCntNext;
  logic             r_abortReq, w_abortReqNext;
  logic             r_doneEvt,  w_doneNext;
  logic             w_launch;
  logic             w_noStall;
  logic             w_abortNow;

  logic [31:0]      w_bufWord;
  logic [IDXW-1:0]  w_last;
  logic [7:0]       w_repeat;
  logic [GAP_W-1:0] w_gap;
  logic             w_startReq;
  logic             w_abort;

  assign u_cfgBus.wdata = cfg_data_i;
  assign u_cfgBus.addr  = cfg_addr_i;
  assign u_cfgBus.valid = cfg_valid_i;
  assign u_cfgBus.rwn   = cfg_rwn_i;
  assign cfg_data_o     = u_cfgBus.rdata;
  assign cfg_ready_o    = 1'b1;

  assign busy_o     = (r_state != ST_IDLE);
  assign done_evt_o = r_doneEvt;

  // Taking over the stream is only safe when no uDMA beat is left hanging
  assign w_noStall = !udma_cmd_valid_i || cmd_ready_i;

  qspi_cmd_seq_regs #(
    .DEPTH (DEPTH),
    .GAP_W (GAP_W)
  ) u_regs (
    .i_sysClk   (sys_clk_i),
    .i_rstn     (rstn_i),
    .cfg        (u_cfgBus),
    .i_busy     (busy_o),
    .i_launch   (w_launch),
    .i_idx      (r_idx),
    .i_passes   (r_passes),
    .o_bufWord  (w_bufWord),
    .o_last     (w_last),
    .o_repeat   (w_repeat),
    .o_gap      (w_gap),
    .o_startReq (w_startReq),
    .o_abort    (w_abort)
  );

  // Sequencer state, word index, pass and gap counters
  always_ff @(posedge sys_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state    <= ST_IDLE;
      r_idx      <= '0;
      r_passes   <= '0;
      r_gapCnt   <= '0;
      r_abortReq <= 1'b0;
      r_doneEvt  <= 1'b0;
    end else begin
      r_state    <= w_stateNext;
      r_idx      <= w_idxNext;
      r_passes   <= w_passesNext;
      r_gapCnt   <= w_gapCntNext;
      r_abortReq <= w_abortReqNext;
      r_doneEvt  <= w_doneNext;
    end
  end

  // Next-state logic and the stream source mux; an abort in SEND is held
  // until the word already on the bus has been accepted
  always_comb begin
    w_stateNext      = r_state;
    w_idxNext        = r_idx;
    w_passesNext     = r_passes;
    w_gapCntNext     = r_gapCnt;
    w_abortReqNext   = r_abortReq;
    w_doneNext       = 1'b0;
    w_launch         = 1'b0;
    w_abortNow       = r_abortReq || w_abort;
    cmd_o            = udma_cmd_i;
    cmd_valid_o      = udma_cmd_valid_i;
    udma_cmd_ready_o = cmd_ready_i;

    case (r_state)
      ST_IDLE: begin
        w_abortReqNext = 1'b0;
        if (w_startReq && w_noStall) begin
          w_launch     = 1'b1;
          w_stateNext  = ST_SEND;
          w_idxNext    = '0;
          w_passesNext = w_repeat;
        end
      end

      ST_SEND: begin
        cmd_o            = w_bufWord;
        cmd_valid_o      = 1'b1;
        udma_cmd_ready_o = 1'b0;
        if (cmd_ready_i) begin
          if (w_abortNow) begin
            w_stateNext    = ST_IDLE;
            w_abortReqNext = 1'b0;
          end else if (r_idx != w_last) begin
            w_idxNext = r_idx + IDXW'(1);
          end else if (r_passes == 8'd0) begin
            w_stateNext = ST_IDLE;
            w_doneNext  = 1'b1;
          end else begin
            w_passesNext = r_passes - 8'd1;
            w_idxNext    = '0;
            if (w_gap != '0) begin
              w_stateNext  = ST_GAP;
              w_gapCntNext = w_gap;
            end
          end
        end else if (w_abort) begin
          w_abortReqNext = 1'b1;
        end
      end

      ST_GAP: begin
        cmd_o            = w_bufWord;
        cmd_valid_o      = 1'b0;
        udma_cmd_ready_o = 1'b0;
        if (w_abort) begin
          w_stateNext = ST_IDLE;
        end else if (r_gapCnt <= GAP_W'(1)) begin
          w_stateNext = ST_SEND;
        end else begin
          w_gapCntNext = r_gapCnt - GAP_W'(1);
        end
      end

      default: w_stateNext = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_udma_qspi_cmd_seq.sv
// Directed bench for the QSPI command sequencer.
module tb_udma_qspi_cmd_seq;
  import qspi_pkg::*;

  localparam logic [31:0] START = 32'h0001_0000;
  localparam logic [31:0] ABORT = 32'h0002_0000;

  logic        clk;
  logic        rstn;
  logic [31:0] udmaCmd;
  logic        udmaValid;
  logic        udmaReady;
  logic [31:0] cmdOut;
  logic        cmdValid;
  logic        cmdReady;
  logic        busy;
  logic        doneEvt;
  logic        cfgReady;

  int nAsserts = 0;
  int nFail    = 0;

  udma_qspi_cmd_seq_if cfgIf ();

  udma_qspi_cmd_seq #(
    .DEPTH (8),
    .GAP_W (16)
  ) dut (
    .sys_clk_i        (clk),
    .rstn_i           (rstn),
    .cfg_data_i       (cfgIf.wdata),
    .cfg_addr_i       (cfgIf.addr),
    .cfg_valid_i      (cfgIf.valid),
    .cfg_rwn_i        (cfgIf.rwn),
    .cfg_ready_o      (cfgReady),
    .cfg_data_o       (cfgIf.rdata),
    .udma_cmd_i       (udmaCmd),
    .udma_cmd_valid_i (udmaValid),
    .udma_cmd_ready_o (udmaReady),
    .cmd_o            (cmdOut),
    .cmd_valid_o      (cmdValid),
    .cmd_ready_i      (cmdReady),
    .busy_o           (busy),
    .done_evt_o       (doneEvt)
  );

  // 100 MHz clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [4:0] a, input logic [31:0] d);
    cfgIf.addr  = a;
    cfgIf.wdata = d;
    cfgIf.rwn   = 1'b0;
    cfgIf.valid = 1'b1;
  endtask

  task automatic idleCfg();
    cfgIf.valid = 1'b0;
    cfgIf.rwn   = 1'b1;
    cfgIf.wdata = '0;
  endtask

  task automatic regWrite(input logic [4:0] a, input logic [31:0] d);
    applyStimulus(a, d);
    tick();
    idleCfg();
  endtask

  task automatic readReg(input logic [4:0] a, output logic [31:0] d);
    cfgIf.addr = a;
    settle();
    d = cfgIf.rdata;
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] pw [3];
    logic [31:0] bufVals [3];
    logic [4:0]  readyPat;
    int          k;
    int          pos;

    pw[0] = 32'hC0DE_0001;
    pw[1] = 32'hC0DE_0002;
    pw[2] = 32'hC0DE_0003;
    bufVals[0] = 32'h0000_00A5;
    bufVals[1] = 32'h0000_0011;
    bufVals[2] = 32'h0000_0022;
    readyPat = 5'b10110;

    rstn      = 1'b0;
    udmaCmd   = '0;
    udmaValid = 1'b0;
    cmdReady  = 1'b1;
    cfgIf.addr = '0;
    idleCfg();

    // Reset values
    #2;
    checkOutput("rst_valid", cmdValid, 0);
    checkOutput("rst_ready", udmaReady, 1);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", doneEvt, 0);
    checkOutput("rst_cfgready", cfgReady, 1);
    readReg(ADDR_STATUS, rd);
    checkOutput("rst_status", rd, 0);
    tick();
    tick();
    rstn = 1'b1;
    tick();

    // Passthrough in IDLE with a varying ready pattern
    k = 0;
    for (int c = 0; c < 5; c++) begin
      udmaValid = 1'b1;
      udmaCmd   = pw[k];
      cmdReady  = readyPat[c];
      settle();
      checkOutput("pt_word", cmdOut, pw[k]);
      checkOutput("pt_valid", cmdValid, 1);
      checkOutput("pt_ready", udmaReady, 32'(readyPat[c]));
      checkOutput("pt_busy", busy, 0);
      if (readyPat[c]) k++;
      tick();
    end
    udmaValid = 1'b0;
    cmdReady  = 1'b1;
    settle();
    checkOutput("pt_idle_valid", cmdValid, 0);

    // Buffer programming, LAST clamp and read-back
    tick();
    regWrite(5'd0, bufVals[0]);
    regWrite(5'd1, bufVals[1]);
    regWrite(5'd2, bufVals[2]);
    regWrite(ADDR_CTRL, 32'h0000_000F);
    readReg(ADDR_CTRL, rd);
    checkOutput("last_clamp", rd, 32'h0000_0007);
    tick();
    readReg(5'd1, rd);
    checkOutput("buf1_read", rd, 32'h0000_0011);
    readReg(5'h13, rd);
    checkOutput("unmapped_read", rd, 0);
    tick();

    // Basic run: three words back to back, then done
    applyStimulus(ADDR_CTRL, 32'h2 | START);
    settle();
    checkOutput("run_t_busy", busy, 0);
    tick();
    idleCfg();
    settle();
    checkOutput("run_t1_busy", busy, 1);
    checkOutput("run_t1_valid", cmdValid, 1);
    checkOutput("run_t1_word", cmdOut, 32'h0000_00A5);
    checkOutput("run_t1_udmaready", udmaReady, 0);
    readReg(ADDR_STATUS, rd);
    checkOutput("run_status", rd, 32'h0000_0001);
    tick();
    settle();
    checkOutput("run_t2_word", cmdOut, 32'h0000_0011);
    tick();
    settle();
    checkOutput("run_t3_word", cmdOut, 32'h0000_0022);
    checkOutput("run_t3_done", doneEvt, 0);
    tick();
    settle();
    checkOutput("run_t4_done", doneEvt, 1);
    checkOutput("run_t4_busy", busy, 0);
    checkOutput("run_t4_valid", cmdValid, 0);
    tick();
    settle();
    checkOutput("run_t5_done", doneEvt, 0);

    // Three passes with a five-cycle gap between them
    regWrite(ADDR_GAP, 32'd5);
    applyStimulus(ADDR_CTRL, 32'h2 | 32'h0000_0200 | START);
    tick();
    idleCfg();
    for (int c = 1; c <= 20; c++) begin
      settle();
      pos = (c - 1) % 8;
      if (c == 20) begin
        checkOutput("rep_done", doneEvt, 1);
        checkOutput("rep_end_busy", busy, 0);
      end else begin
        checkOutput("rep_valid", cmdValid, (pos < 3) ? 1 : 0);
        if (pos < 3) checkOutput("rep_word", cmdOut, bufVals[pos]);
        checkOutput("rep_nodone", doneEvt, 0);
        checkOutput("rep_busy", busy, 1);
      end
      if (c == 5) begin
        readReg(ADDR_STATUS, rd);
        checkOutput("rep_status", rd, 32'h0000_0101);
      end
      tick();
    end

    // START while an upstream beat is stalled
    udmaValid = 1'b1;
    udmaCmd   = 32'hDEAD_0001;
    cmdReady  = 1'b0;
    applyStimulus(ADDR_CTRL, 32'h2 | START);
    settle();
    checkOutput("stall_t_word", cmdOut, 32'hDEAD_0001);
    checkOutput("stall_t_busy", busy, 0);
    tick();
    applyStimulus(5'd0, 32'h0000_00FF);
    settle();
    checkOutput("stall_t1_busy", busy, 0);
    checkOutput("stall_t1_word", cmdOut, 32'hDEAD_0001);
    checkOutput("stall_t1_valid", cmdValid, 1);
    tick();
    idleCfg();
    cmdReady = 1'b1;
    settle();
    checkOutput("stall_t2_word", cmdOut, 32'hDEAD_0001);
    checkOutput("stall_t2_udmaready", udmaReady, 1);
    checkOutput("stall_t2_busy", busy, 0);
    readReg(ADDR_STATUS, rd);
    checkOutput("stall_status", rd, 32'h0000_0002);
    tick();
    udmaValid = 1'b0;
    settle();
    checkOutput("stall_t3_busy", busy, 1);
    checkOutput("stall_t3_word", cmdOut, 32'h0000_00A5);
    checkOutput("stall_t3_valid", cmdValid, 1);
    tick();
    settle();
    checkOutput("stall_t4_word", cmdOut, 32'h0000_0011);
    tick();
    settle();
    checkOutput("stall_t5_word", cmdOut, 32'h0000_0022);
    tick();
    settle();
    checkOutput("stall_t6_done", doneEvt, 1);
    tick();

    // ABORT in SEND while ready is low
    cmdReady = 1'b0;
    applyStimulus(ADDR_CTRL, 32'h2 | START);
    tick();
    applyStimulus(ADDR_CTRL, ABORT);
    settle();
    checkOutput("abs_t1_word", cmdOut, 32'h0000_00A5);
    checkOutput("abs_t1_busy", busy, 1);
    tick();
    idleCfg();
    settle();
    checkOutput("abs_t2_word", cmdOut, 32'h0000_00A5);
    checkOutput("abs_t2_valid", cmdValid, 1);
    checkOutput("abs_t2_busy", busy, 1);
    tick();
    cmdReady = 1'b1;
    settle();
    checkOutput("abs_t3_word", cmdOut, 32'h0000_00A5);
    checkOutput("abs_t3_valid", cmdValid, 1);
    tick();
    settle();
    checkOutput("abs_t4_busy", busy, 0);
    checkOutput("abs_t4_done", doneEvt, 0);
    checkOutput("abs_t4_valid", cmdValid, 0);
    tick();
    settle();
    checkOutput("abs_t5_done", doneEvt, 0);

    // ABORT during the inter-pass gap
    applyStimulus(ADDR_CTRL, 32'h0 | 32'h0000_0100 | START);
    tick();
    idleCfg();
    settle();
    checkOutput("abg_t1_word", cmdOut, 32'h0000_00A5);
    tick();
    settle();
    checkOutput("abg_t2_valid", cmdValid, 0);
    checkOutput("abg_t2_busy", busy, 1);
    applyStimulus(ADDR_CTRL, ABORT);
    tick();
    idleCfg();
    settle();
    checkOutput("abg_t3_busy", busy, 0);
    checkOutput("abg_t3_done", doneEvt, 0);
    tick();
    settle();
    checkOutput("abg_t4_done", doneEvt, 0);

    // ABORT and START in the same write
    applyStimulus(ADDR_CTRL, 32'h2 | START | ABORT);
    tick();
    idleCfg();
    settle();
    checkOutput("both_busy", busy, 0);
    readReg(ADDR_STATUS, rd);
    checkOutput("both_status", rd, 0);
    tick();
    settle();
    checkOutput("both_busy_later", busy, 0);

    // Reset in the middle of SEND
    cmdReady = 1'b0;
    applyStimulus(ADDR_CTRL, 32'h2 | START);
    tick();
    idleCfg();
    settle();
    checkOutput("rsend_busy", busy, 1);
    rstn     = 1'b0;
    cmdReady = 1'b1;
    settle();
    checkOutput("rsend_rst_busy", busy, 0);
    checkOutput("rsend_rst_valid", cmdValid, 0);
    checkOutput("rsend_rst_udmaready", udmaReady, 1);
    checkOutput("rsend_rst_done", doneEvt, 0);
    tick();
    rstn = 1'b1;
    tick();
    readReg(5'd0, rd);
    checkOutput("rsend_buf0", rd, 0);
    readReg(ADDR_CTRL, rd);
    checkOutput("rsend_ctrl", rd, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule

// File: doc/udma_qspi_cmd_seq.md
# udma_qspi_cmd_seq

Hardware command sequencer placed directly upstream of the QSPI master's command stream input. It stores a short programmable list of SPI command words and replays it autonomously, with an optional repeat count and inter-pass gap (e.g. flash status polling or boot-time reads). It arbitrates between its own list and the uDMA command channel, so software-driven traffic and sequenced traffic share one command port without breaking stream handshakes.

## Interface
- DEPTH, 8, command buffer entries (power of two, 2..16)
- GAP_W, 16, width of inter-pass gap counter
- sys_clk_i  in  1  single clock; all logic on rising edge
- rstn_i  in  1  asynchronous active-low reset
- cfg_data_i  in  32  register write data
- cfg_addr_i  in  5  register address
- cfg_valid_i  in  1  register access strobe
- cfg_rwn_i  in  1  1 = read, 0 = write
- cfg_ready_o  out  1  tied 1
- cfg_data_o  out  32  read data, combinational from cfg_addr_i
- udma_cmd_i  in  32  uDMA command channel data
- udma_cmd_valid_i  in  1  uDMA command valid
- udma_cmd_ready_o  out  1  uDMA command ready
- cmd_o  out  32  command word to QSPI master
- cmd_valid_o  out  1  command valid
- cmd_ready_i  in  1  QSPI master ready
- busy_o  out  1  sequencer owns cmd_o (state != IDLE)
- done_evt_o  out  1  one-cycle pulse at sequence completion

## Operation
- Registers: 0..DEPTH-1 = BUF[i] (R/W); 0x10 CTRL: [3:0] LAST index, [15:8] REPEAT, [16] START (write-1, self-clearing), [17] ABORT (write-1, self-clearing); 0x11 GAP[GAP_W-1:0]; 0x12 STATUS (RO): [0] busy, [1] start_pending, [15:8] passes remaining. Unmapped reads return 0.
- Writes to BUF, CTRL.LAST/REPEAT and GAP are ignored while busy_o or start_pending; ABORT is always accepted.
- States: IDLE, SEND, GAP.
- IDLE: passthrough, cmd_o = udma_cmd_i, cmd_valid_o = udma_cmd_valid_i, udma_cmd_ready_o = cmd_ready_i.
- START sets start_pending. Leave IDLE to SEND when start_pending and the passthrough has no stalled beat (!udma_cmd_valid_i || cmd_ready_i); clear start_pending and load idx = 0, passes = REPEAT.
- SEND: cmd_o = BUF[idx], cmd_valid_o = 1, udma_cmd_ready_o = 0. On handshake: if idx != LAST then idx++; else if passes == 0 then go to IDLE and pulse done_evt_o; else passes--, idx = 0, and go to GAP if GAP != 0, otherwise stay in SEND.
- GAP: cmd_valid_o = 0, udma_cmd_ready_o = 0; count GAP cycles, then go to SEND.
- ABORT: start_pending cleared. In GAP, go to IDLE next cycle. In SEND, the current word stays valid until its handshake completes (a stream rule), then go to IDLE. No done_evt_o on abort.
- START while busy is ignored. LAST > DEPTH-1 is clamped to DEPTH-1.

## Timing
- Reset values: all registers 0, state IDLE, cmd_valid_o follows udma_cmd_valid_i (0 when that is 0), udma_cmd_ready_o follows cmd_ready_i, busy_o 0, done_evt_o 0, cfg_ready_o 1.
- START written at cycle t with the upstream idle: SEND at t+1, cmd_valid_o = 1 with BUF[0] at t+1.
- Back-to-back: one word per cycle while cmd_ready_i = 1.
- Gap: exactly GAP cycles with cmd_valid_o = 0 between the last word of one pass and the first word of the next.
- done_evt_o is high in the cycle after the final handshake, the same cycle the state returns to IDLE and passthrough resumes.
- Once cmd_valid_o is asserted, cmd_o is stable until the handshake in every state. A source switch happens only after a handshake or while valid is low.
- Simultaneous ABORT and START write: ABORT wins.

## Structure
- A shared package (qspi_pkg) holds the register offsets, CTRL bit positions and the state enum.
- One sub-module, qspi_cmd_seq_regs, contains the register file, buffer and read mux. The FSM, counters and arbitration mux live in the top module.

## Test plan
- Passthrough: in IDLE, drive 3 uDMA words with random cmd_ready_i -> identical words appear on cmd_o in order and busy_o stays 0.
- Basic run: BUF = {0xA5, 0x11, 0x22}, LAST = 2, REPEAT = 0, START, cmd_ready_i = 1 -> words appear at t+1..t+3 and done_evt_o pulses at t+4.
- Repeat with gap: REPEAT = 2, GAP = 5 -> 3 passes with exactly 5 idle cycles between passes and one done_evt_o.
- Stalled upstream: uDMA word valid with cmd_ready_i = 0 when START is written -> that word completes first, then BUF[0] follows, with no word lost or duplicated.
- Abort in SEND with ready held low: the current word stays stable until ready, then IDLE with no done_evt_o. Abort in GAP -> IDLE next cycle.
- Reset mid-SEND: assert rstn_i -> all outputs return to reset values immediately and busy_o = 0.
